cmp_pipe: RTL and testbench

Parametrised, pipelined magnitude comparator for two WIDTH-bit operands, unsigned or two's-complement per transaction.
- Generalises the 4-bit equality comparator: one result carries eq, lt and gt, and the operands can be of any chunk-multiple width.
- Processes CHUNK bits per stage, MSB chunk first, with valid/ready handshakes on both sides.
- Keeps a saturating count of equal results.
- Sits between a data source (counter or register bank) and control logic that needs ordered compare results at full clock rate.

---
 rtl/cmp_pipe_pkg.sv | 22 ++
 rtl/cmp_pipe_if.sv | 27 ++
 rtl/cmp_pipe_stage.sv | 54 +++++
 rtl/cmp_pipe.sv | 68 ++++++
 tb/tb_cmp_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_pipe_pkg.sv
// Shared types and helpers for the chunked, pipelined magnitude comparator.
// Imported by the interface, the stage module and the top.
package cmp_pipe_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;
   localparam int STAGES    = DEF_WIDTH / DEF_CHUNK;

   // State handed from one stage to the next alongside the operands
   typedef struct packed {
      logic valid;
      logic decided;
      logic lt;
      logic gt;
   } stg_t;

   // MSB index of the chunk compared by stage k (MSB chunk first)
   function automatic int chunk_hi(input int width, input int chunk, input int k);
      return width - 1 - k * chunk;
   endfunction

endpackage

// File: rtl/cmp_pipe_if.sv
// Operand / result handshake bundle for cmp_pipe.
// Valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1; a producer holds
// its payload stable while valid=1 and ready=0, and valid never depends combinationally on ready.
interface cmp_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] i0;
   logic [WIDTH-1:0] i1;
   logic             sgn;
   logic             out_valid;
   logic             out_ready;
   logic             eq;
   logic             lt;
   logic             gt;

   modport master (
      output in_valid, i0, i1, sgn, out_ready,
      input  in_ready, out_valid, eq, lt, gt
   );

   modport slave (
      input  in_valid, i0, i1, sgn, out_ready,
      output in_ready, out_valid, eq, lt, gt
   );
endinterface

// File: rtl/cmp_pipe_stage.sv
// One registered comparator stage: compares chunk K of both operands unless an earlier
// (more significant) chunk already decided the order, then forwards the operands.
module cmp_stage
   import cmp_pipe_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4,
   parameter int K     = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   input  stg_t             s_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output stg_t             s_out,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out
);
   localparam int HI = chunk_hi(WIDTH, CHUNK, K);

   logic [CHUNK-1:0] ca;
   logic [CHUNK-1:0] cb;
   stg_t             nxt;

   assign ca = a_in[HI -: CHUNK];
   assign cb = b_in[HI -: CHUNK];

   always_comb begin
      nxt = s_in;
      if (s_in.valid && !s_in.decided && (ca != cb)) begin
         nxt.decided = 1'b1;
         nxt.lt      = (ca < cb);
         nxt.gt      = (ca > cb);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_out <= '0;
      end else if (adv) begin
         s_out <= nxt;
      end
   end

   // Operand payload needs no reset: it is only meaningful alongside s_out.valid
   always_ff @(posedge clk) begin
      if (adv) begin
         a_out <= a_in;
         b_out <= b_in;
      end
   end

endmodule

// File: rtl/cmp_pipe.sv
// Pipelined WIDTH-bit magnitude comparator (unsigned or two's complement per transaction)
// with a global advance/stall and a saturating count of consumed equal results.
module cmp_pipe
   import cmp_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   cmp_pipe_if.slave        bus,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] eq_cnt
);
   localparam int               NSTG     = WIDTH / CHUNK;
   localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

   logic             adv;
   stg_t             st  [0:NSTG];
   logic [WIDTH-1:0] a_q [0:NSTG];
   logic [WIDTH-1:0] b_q [0:NSTG];
   logic             unused_tail;

   // Whole pipe moves together; a stalled result at the output freezes every stage, bubbles included
   assign adv          = ~bus.out_valid | bus.out_ready;
   assign bus.in_ready = adv;

   assign st[0] = '{valid: bus.in_valid & adv, decided: 1'b0, lt: 1'b0, gt: 1'b0};

   // Flipping the sign bit maps two's-complement order onto unsigned order
   assign a_q[0] = bus.sgn ? (bus.i0 ^ SIGN_BIT) : bus.i0;
   assign b_q[0] = bus.sgn ? (bus.i1 ^ SIGN_BIT) : bus.i1;

   for (genvar k = 0; k < NSTG; k++) begin : g_stage
      cmp_stage #(
         .WIDTH (WIDTH),
         .CHUNK (CHUNK),
         .K     (k)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .adv   (adv),
         .s_in  (st[k]),
         .a_in  (a_q[k]),
         .b_in  (b_q[k]),
         .s_out (st[k+1]),
         .a_out (a_q[k+1]),
         .b_out (b_q[k+1])
      );
   end

   assign bus.out_valid = st[NSTG].valid;
   assign bus.lt        = st[NSTG].lt;
   assign bus.gt        = st[NSTG].gt;
   assign bus.eq        = st[NSTG].valid & ~st[NSTG].lt & ~st[NSTG].gt;

   assign unused_tail = ^{a_q[NSTG], b_q[NSTG], st[NSTG].decided};

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         eq_cnt <= '0;
      end else if (bus.out_valid && bus.out_ready && bus.eq && (eq_cnt != '1)) begin
         eq_cnt <= eq_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_cmp_pipe.sv
// Self-checking bench for cmp_pipe: directed ordering cases, streaming, backpressure,
// counter saturation (second instance with CNT_W=2), reset flush and random traffic.
module tb_cmp_pipe;
   localparam int W   = 16;
   localparam int C   = 4;
   localparam int NST = W / C;

   logic        clk = 1'b0;
   logic        rst;
   logic        cnt_clr;
   logic [15:0] eq_cnt;
   logic [1:0]  eq_cnt2;
   logic        rand_rdy;

   cmp_pipe_if #(.WIDTH(W)) bus  ();
   cmp_pipe_if #(.WIDTH(W)) bus2 ();

   always #5 clk = ~clk;

   cmp_pipe #(.WIDTH(W), .CHUNK(C), .CNT_W(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .cnt_clr (cnt_clr),
      .eq_cnt  (eq_cnt)
   );

   // Narrow-counter instance runs in lockstep on the same stimulus
   assign bus2.in_valid  = bus.in_valid;
   assign bus2.i0        = bus.i0;
   assign bus2.i1        = bus.i1;
   assign bus2.sgn       = bus.sgn;
   assign bus2.out_ready = bus.out_ready;

   cmp_pipe #(.WIDTH(W), .CHUNK(C), .CNT_W(2)) dut2 (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus2),
      .cnt_clr (cnt_clr),
      .eq_cnt  (eq_cnt2)
   );

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [2:0]  exp_q[$];
   int          tag_q[$];
   int          cyc       = 0;
   int          stall_cnt = 0;
   int          mdl_cnt   = 0;
   int          mdl_cnt2  = 0;
   logic        held      = 1'b0;
   logic [2:0]  held_res  = 3'b000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: order of the two operands as plain integers; result coded {eq,lt,gt}
   function automatic logic [2:0] ref_cmp(input logic [15:0] a, input logic [15:0] b, input logic s);
      int va;
      int vb;
      va = s ? int'($signed(a)) : int'(a);
      vb = s ? int'($signed(b)) : int'(b);
      if (va == vb) return 3'b100;
      if (va < vb)  return 3'b010;
      return 3'b001;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [2:0] res;
      logic [2:0] res2;
      logic [2:0] e;
      logic       consumed_eq;
      consumed_eq = 1'b0;
      res  = {bus.eq, bus.lt, bus.gt};
      res2 = {bus2.eq, bus2.lt, bus2.gt};
      if (rst) begin
         exp_q.delete();
         tag_q.delete();
         mdl_cnt  = 0;
         mdl_cnt2 = 0;
         held     = 1'b0;
      end else begin
         check("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
         check("in_ready_rule2", 32'(bus2.in_ready), 32'(!bus2.out_valid || bus2.out_ready));
         check("eq_cnt", 32'(eq_cnt), 32'(mdl_cnt));
         check("eq_cnt_w2", 32'(eq_cnt2), 32'(mdl_cnt2));
         if (held) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_stable", 32'(res), 32'(held_res));
         end
         if (bus.out_valid) begin
            check("onehot", 32'($countones(res)), 32'd1);
            check("valid_w2", 32'(bus2.out_valid), 32'd1);
            if (!held) begin
               if (exp_q.size() == 0) begin
                  check("spurious_result", 32'(bus.out_valid), 32'd0);
               end else begin
                  check("result", 32'(res), 32'(exp_q[0]));
                  check("result_w2", 32'(res2), 32'(exp_q[0]));
                  check("latency", 32'((cyc - stall_cnt) - tag_q[0]), 32'(NST));
               end
            end
            if (bus.out_ready) begin
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  void'(tag_q.pop_front());
                  consumed_eq = (e == 3'b100);
               end
               held = 1'b0;
            end else begin
               held      = 1'b1;
               held_res  = res;
               stall_cnt = stall_cnt + 1;
            end
         end else begin
            held = 1'b0;
         end
         if (cnt_clr) begin
            mdl_cnt  = 0;
            mdl_cnt2 = 0;
         end else if (consumed_eq) begin
            if (mdl_cnt < 65535) mdl_cnt = mdl_cnt + 1;
            if (mdl_cnt2 < 3)    mdl_cnt2 = mdl_cnt2 + 1;
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_cmp(bus.i0, bus.i1, bus.sgn));
            tag_q.push_back(cyc - stall_cnt);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) begin
         bus.out_ready = ($urandom_range(0, 99) < 70);
         cnt_clr       = ($urandom_range(0, 59) == 0);
      end
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
      logic acc;
      int   n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.i0       = a;
      bus.i1       = b;
      bus.sgn      = s;
      forever begin
         @(negedge clk);
         acc = bus.in_ready;
         tick();
         if (acc) break;
         n++;
         if (n > 1000) begin
            check("send_timeout", 32'(n), 32'd0);
            break;
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         tick();
         n++;
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!bus.out_valid && n < 100) begin
         tick();
         n++;
      end
      check("wait_valid", 32'(bus.out_valid), 32'd1);
   endtask

   task automatic rand_ops(output logic [15:0] a, output logic [15:0] b);
      logic [15:0] corner [4];
      int          m;
      corner = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
      m = int'($urandom_range(0, 4));
      a = 16'($urandom);
      case (m)
         0: b = a;
         1: begin
            b = a;
            b[4*$urandom_range(0, 3) +: 4] = 4'($urandom);
         end
         2: b = a ^ 16'($urandom_range(1, 15));
         3: begin
            a = corner[$urandom_range(0, 3)];
            b = corner[$urandom_range(0, 3)];
         end
         default: b = 16'($urandom);
      endcase
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] a;
      logic [15:0] b;
      bus.in_valid  = 1'b0;
      bus.i0        = '0;
      bus.i1        = '0;
      bus.sgn       = 1'b0;
      bus.out_ready = 1'b1;
      cnt_clr       = 1'b0;
      rand_rdy      = 1'b0;
      rst           = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_flags", 32'({bus.eq, bus.lt, bus.gt}), 32'd0);
      check("rst_eq_cnt", 32'(eq_cnt), 32'd0);
      check("rst_eq_cnt_w2", 32'(eq_cnt2), 32'd0);

      // Ordering corners, unsigned and signed
      send(16'h1234, 16'h1235, 1'b0);
      send(16'hF000, 16'h0FFF, 1'b0);
      send(16'hFFFF, 16'h0001, 1'b1);
      send(16'hFFFF, 16'h0001, 1'b0);
      send(16'h8000, 16'h7FFF, 1'b1);
      send(16'h7FFF, 16'h8000, 1'b1);
      send(16'hABCD, 16'hABCD, 1'b0);
      send(16'h8000, 16'h8000, 1'b1);
      drain();

      // Back-to-back streaming
      for (int i = 0; i < 8; i++) begin
         check("stream_in_ready", 32'(bus.in_ready), 32'd1);
         rand_ops(a, b);
         send(a, b, 1'($urandom_range(0, 1)));
      end
      drain();

      // Backpressure with a result parked at the output
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rand_ops(a, b);
         send(a, b, 1'($urandom_range(0, 1)));
      end
      wait_valid();
      for (int i = 0; i < 3; i++) begin
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
         check("bp_out_valid", 32'(bus.out_valid), 32'd1);
         tick();
      end
      bus.out_ready = 1'b1;
      drain();

      // Counter: five equal results, then clear racing a consume
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a = 16'($urandom);
         send(a, a, 1'($urandom_range(0, 1)));
      end
      drain();
      check("cnt_five", 32'(eq_cnt), 32'd5);
      check("cnt_sat_w2", 32'(eq_cnt2), 32'd3);
      a = 16'($urandom);
      send(a, a, 1'b0);
      wait_valid();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("clr_wins", 32'(eq_cnt), 32'd0);
      check("clr_wins_w2", 32'(eq_cnt2), 32'd0);

      // Random traffic with random backpressure and occasional clears
      rand_rdy = 1'b1;
      for (int i = 0; i < 400; i++) begin
         rand_ops(a, b);
         send(a, b, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) tick();
      end
      rand_rdy      = 1'b0;
      bus.out_ready = 1'b1;
      cnt_clr       = 1'b0;
      drain();

      // Reset with three transactions in flight
      a = 16'($urandom);
      send(a, a, 1'b1);
      drain();
      for (int i = 0; i < 3; i++) begin
         rand_ops(a, b);
         send(a, b, 1'($urandom_range(0, 1)));
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("flush_out_valid", 32'(bus.out_valid), 32'd0);
      check("flush_eq_cnt", 32'(eq_cnt), 32'd0);
      check("flush_eq_cnt_w2", 32'(eq_cnt2), 32'd0);
      repeat (10) tick();
      check("flush_no_stale", 32'(bus.out_valid), 32'd0);

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
